// File: rtl/segment_saver_sequencer.sv
// Segment-saver sequencer: walks one lit segment across NUM_SEGS positions at a
// tick-derived rate in chase-up, chase-down, bounce or hold mode.
module segment_saver_sequencer #(
  parameter int NUM_SEGS = 7,
  parameter int DWELL_W  = 8,
  localparam int IDX_W   = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                clear,
  input  logic                tick,
  input  logic [1:0]          mode,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [IDX_W-1:0]    seg_idx,
  output logic [NUM_SEGS-1:0] seg_onehot,
  output logic                step_pulse,
  output logic                cycle_done
);

  localparam logic [1:0] MODE_CHASE_UP   = 2'b00;
  localparam logic [1:0] MODE_CHASE_DOWN = 2'b01;
  localparam logic [1:0] MODE_BOUNCE     = 2'b10;
  localparam logic [1:0] MODE_HOLD       = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [IDX_W-1:0]    IDX_ZERO = '0;
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_SEGS - 1);
  localparam logic [DWELL_W-1:0]  CNT_ONE  = DWELL_W'(1);
  localparam logic [NUM_SEGS-1:0] OH_ONE   = NUM_SEGS'(1);

  logic [IDX_W-1:0]   seg_idx_q, seg_idx_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               step_pulse_q, step_pulse_d;
  logic               cycle_done_q, cycle_done_d;

  logic               step_now;
  logic [IDX_W-1:0]   nxt_idx;
  logic               nxt_dir;
  logic               nxt_wrap;

  // State register: index, direction, dwell counter and the two registered pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_idx_q    <= IDX_ZERO;
      dir_q        <= DIR_UP;
      dwell_cnt_q  <= '0;
      step_pulse_q <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      seg_idx_q    <= seg_idx_d;
      dir_q        <= dir_d;
      dwell_cnt_q  <= dwell_cnt_d;
      step_pulse_q <= step_pulse_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  // Where the next step would land under the current mode; wrap marks pattern end.
  always_comb begin
    nxt_idx  = seg_idx_q;
    nxt_dir  = dir_q;
    nxt_wrap = 1'b0;
    case (mode)
      MODE_CHASE_UP: begin
        nxt_dir = DIR_UP;
        if (seg_idx_q >= IDX_LAST) begin
          nxt_idx  = IDX_ZERO;
          nxt_wrap = 1'b1;
        end else begin
          nxt_idx = seg_idx_q + IDX_ONE;
        end
      end
      MODE_CHASE_DOWN: begin
        nxt_dir = DIR_DOWN;
        if (seg_idx_q == IDX_ZERO) begin
          nxt_idx  = IDX_LAST;
          nxt_wrap = 1'b1;
        end else begin
          nxt_idx = seg_idx_q - IDX_ONE;
        end
      end
      MODE_BOUNCE: begin
        // A bounce pattern completes on the step that arrives at 0 moving down.
        if (NUM_SEGS == 1) begin
          nxt_idx  = IDX_ZERO;
          nxt_wrap = 1'b1;
        end else if (dir_q == DIR_UP) begin
          if (seg_idx_q >= IDX_LAST) begin
            nxt_idx  = IDX_LAST - IDX_ONE;
            nxt_dir  = DIR_DOWN;
            nxt_wrap = (IDX_LAST == IDX_ONE);
          end else begin
            nxt_idx = seg_idx_q + IDX_ONE;
          end
        end else begin
          if (seg_idx_q == IDX_ZERO) begin
            nxt_idx = IDX_ONE;
            nxt_dir = DIR_UP;
          end else begin
            nxt_idx  = seg_idx_q - IDX_ONE;
            nxt_wrap = (seg_idx_q == IDX_ONE);
          end
        end
      end
      default: begin
        nxt_idx  = seg_idx_q;
        nxt_dir  = dir_q;
        nxt_wrap = 1'b0;
      end
    endcase
  end

  // Next-state selection in priority order: clear, enable, hold, dwell/step.
  always_comb begin
    seg_idx_d    = seg_idx_q;
    dir_d        = dir_q;
    dwell_cnt_d  = dwell_cnt_q;
    step_pulse_d = 1'b0;
    cycle_done_d = 1'b0;
    step_now     = 1'b0;
    if (clear) begin
      seg_idx_d   = IDX_ZERO;
      dir_d       = DIR_UP;
      dwell_cnt_d = '0;
    end else if (!en) begin
      dwell_cnt_d = dwell_cnt_q;
    end else if (mode == MODE_HOLD) begin
      dwell_cnt_d = '0;
    end else if (tick) begin
      // >= rather than == so that lowering dwell mid-count steps on the next tick.
      if (dwell_cnt_q >= dwell) begin
        step_now    = 1'b1;
        dwell_cnt_d = '0;
      end else begin
        dwell_cnt_d = dwell_cnt_q + CNT_ONE;
      end
    end
    if (step_now) begin
      seg_idx_d    = nxt_idx;
      dir_d        = nxt_dir;
      step_pulse_d = 1'b1;
      cycle_done_d = nxt_wrap;
    end
  end

  // Outputs: step_pulse is the valid strobe for the new seg_idx; it has no ready and
  // is high for exactly the one clk after the stepping edge, with cycle_done alongside.
  assign seg_idx    = seg_idx_q;
  assign step_pulse = step_pulse_q;
  assign cycle_done = cycle_done_q;
  assign seg_onehot = en ? (OH_ONE << seg_idx_q) : '0;

endmodule

// File: tb/tb_segment_saver_sequencer.sv
// Directed bench for segment_saver_sequencer: expected steps queued by stimulus,
// checked by a negedge monitor against what the DUT presents on step_pulse.
module tb_segment_saver_sequencer;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       clear;
  logic       tick;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic [2:0] seg_idx;
  logic [6:0] seg_onehot;
  logic       step_pulse;
  logic       cycle_done;

  segment_saver_sequencer #(.NUM_SEGS(7), .DWELL_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .clear      (clear),
    .tick       (tick),
    .mode       (mode),
    .dwell      (dwell),
    .seg_idx    (seg_idx),
    .seg_onehot (seg_onehot),
    .step_pulse (step_pulse),
    .cycle_done (cycle_done)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [3:0] exp_q[$];   // {cycle_done, seg_idx} expected with each step_pulse
  chk_t       chk_q[$];   // point-in-time checks sampled by the stimulus
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [4:0] mon_got;
  logic [4:0] mon_req;
  logic [3:0] mon_e;
  chk_t       mon_c;

  always @(negedge clk) begin
    if (reset_n && (step_pulse || cycle_done)) begin
      n_cmp++;
      mon_got = {step_pulse, cycle_done, seg_idx};
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_step: got pulse=%0b done=%0b idx=%0d, required no pulse",
                 step_pulse, cycle_done, seg_idx);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_req = {1'b1, mon_e};
        if (mon_got !== mon_req) begin
          n_bad++;
          $display("FAIL step_output: got pulse=%0b done=%0b idx=%0d, required pulse=1 done=%0b idx=%0d",
                   step_pulse, cycle_done, seg_idx, mon_e[3], mon_e[2:0]);
        end
      end
    end
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      n_cmp++;
      if (mon_c.act !== mon_c.exp) begin
        n_bad++;
        $display("FAIL %s: got %0d, required %0d", mon_c.name, mon_c.act, mon_c.exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_no_step(input int n);
    tick = 1'b1;
    idle(n);
    tick = 1'b0;
  endtask

  // One qualifying tick; queues the expected step and checks index/onehot after the edge.
  task automatic tick_expect(input logic cd, input int idx);
    logic [6:0] oh;
    logic [2:0] i3;
    i3 = idx[2:0];
    oh = 7'b0000001 << i3;
    exp_q.push_back({cd, i3});
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    chk("step_seg_idx", 32'(seg_idx), 32'(i3));
    chk("step_onehot", 32'(seg_onehot), 32'(oh));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    en      = 1'b0;
    clear   = 1'b0;
    tick    = 1'b0;
    mode    = 2'b00;
    dwell   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_seg_idx", 32'(seg_idx), 32'd0);
    chk("reset_step_pulse", 32'(step_pulse), 32'd0);
    chk("reset_cycle_done", 32'(cycle_done), 32'd0);
    chk("reset_onehot_en_low", 32'(seg_onehot), 32'd0);
    reset_n = 1'b1;
    en      = 1'b1;
    idle(1);
    chk("post_reset_onehot", 32'(seg_onehot), 32'b0000001);

    // Chase up, dwell 0, tick every clk: 1..6, wrap to 0 with cycle_done, then 1.
    tick_expect(1'b0, 1);
    tick_expect(1'b0, 2);
    tick_expect(1'b0, 3);
    tick_expect(1'b0, 4);
    tick_expect(1'b0, 5);
    tick_expect(1'b0, 6);
    tick_expect(1'b1, 0);
    tick_expect(1'b0, 1);
    idle(2);

    // dwell 3, tick every 4th clk: step only on every 4th tick, pulse exactly 1 clk.
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clear_seg_idx", 32'(seg_idx), 32'd0);
    dwell = 8'd3;
    for (int t = 0; t < 8; t++) begin
      if ((t % 4) == 3) begin
        tick_expect(1'b0, (t + 1) / 4);
        chk("dwell_pulse_high", 32'(step_pulse), 32'd1);
        idle(1);
        chk("dwell_pulse_width", 32'(step_pulse), 32'd0);
        idle(2);
      end else begin
        tick_no_step(1);
        chk("dwell_hold_idx", 32'(seg_idx), 32'(t / 4));
        idle(3);
      end
    end

    // Bounce from 0: 1..6, 5..0 (done on reaching 0), then 1.
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    mode  = 2'b10;
    dwell = 8'd0;
    tick_expect(1'b0, 1);
    tick_expect(1'b0, 2);
    tick_expect(1'b0, 3);
    tick_expect(1'b0, 4);
    tick_expect(1'b0, 5);
    tick_expect(1'b0, 6);
    tick_expect(1'b0, 5);
    tick_expect(1'b0, 4);
    tick_expect(1'b0, 3);
    tick_expect(1'b0, 2);
    tick_expect(1'b0, 1);
    tick_expect(1'b1, 0);
    tick_expect(1'b0, 1);
    idle(2);

    // Chase up to 4, freeze with en low for 10 ticks, then resume to 5.
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    mode  = 2'b00;
    tick_expect(1'b0, 1);
    tick_expect(1'b0, 2);
    tick_expect(1'b0, 3);
    tick_expect(1'b0, 4);
    idle(1);
    en   = 1'b0;
    tick = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      chk("en_low_seg_idx", 32'(seg_idx), 32'd4);
      chk("en_low_onehot", 32'(seg_onehot), 32'd0);
      chk("en_low_step_pulse", 32'(step_pulse), 32'd0);
    end
    tick = 1'b0;
    en   = 1'b1;
    tick_expect(1'b0, 5);
    idle(2);

    // Clear coincident with a qualifying tick at idx 5.
    clear = 1'b1;
    tick  = 1'b1;
    idle(1);
    clear = 1'b0;
    tick  = 1'b0;
    chk("clear_tick_seg_idx", 32'(seg_idx), 32'd0);
    chk("clear_tick_no_pulse", 32'(step_pulse), 32'd0);
    chk("clear_tick_no_done", 32'(cycle_done), 32'd0);

    // Async reset while a step pulse is high.
    tick_expect(1'b0, 1);
    tick_expect(1'b0, 2);
    tick_no_step(1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_pulse_idx", 32'(seg_idx), 32'd0);
    chk("rst_mid_pulse_pulse", 32'(step_pulse), 32'd0);
    chk("rst_mid_pulse_done", 32'(cycle_done), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Async reset mid-dwell, then a full fresh dwell is needed before the next step.
    tick_expect(1'b0, 1);
    dwell = 8'd3;
    tick_no_step(2);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_dwell_idx", 32'(seg_idx), 32'd0);
    chk("rst_mid_dwell_onehot", 32'(seg_onehot), 32'b0000001);
    chk("rst_mid_dwell_pulse", 32'(step_pulse), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick_no_step(3);
    chk("rst_dwell_restart_idx", 32'(seg_idx), 32'd0);
    tick_expect(1'b0, 1);
    idle(2);

    // dwell lowered from 200 to 2 with 50 ticks counted: step on the very next tick.
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    dwell = 8'd200;
    tick_no_step(50);
    chk("dwell200_idx", 32'(seg_idx), 32'd0);
    dwell = 8'd2;
    tick_expect(1'b0, 1);
    idle(2);

    // Chase down from 0 wraps to 6 with cycle_done.
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    mode  = 2'b01;
    dwell = 8'd0;
    tick_expect(1'b1, 6);
    tick_expect(1'b0, 5);
    idle(2);

    // Hold keeps the index and clears the partial dwell count.
    mode  = 2'b00;
    dwell = 8'd2;
    tick_no_step(1);
    mode = 2'b11;
    tick_no_step(3);
    chk("hold_seg_idx", 32'(seg_idx), 32'd5);
    mode = 2'b00;
    tick_no_step(2);
    chk("hold_dwell_cleared", 32'(seg_idx), 32'd5);
    tick_expect(1'b0, 6);
    idle(3);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
